// File: rtl/charge_session_if.sv
// Key-event and session-status bundle between the keyboard scanner side (master)
// and the charge session controller (slave).
interface charge_session_if;
    logic [3:0] key_value;
    logic       press_num;
    logic       start;
    logic       clear;
    logic       confirm;
    logic [1:0] state;
    logic       power_on;
    logic       charging;
    logic [6:0] amount;
    logic [1:0] digit_cnt;
    logic [7:0] remaining;
    logic       done;

    modport master (
        output key_value, press_num, start, clear, confirm,
        input  state, power_on, charging, amount, digit_cnt, remaining, done
    );

    modport slave (
        input  key_value, press_num, start, clear, confirm,
        output state, power_on, charging, amount, digit_cnt, remaining, done
    );
endinterface

// File: rtl/charge_session_ctrl.sv
// Charge session controller: power-on, 2-digit amount entry, timed countdown, idle timeout.
// Optional macro CHARGE_ABORT_EN: clear during CHARGE aborts the charge without pulsing done.
module charge_session_ctrl #(
    parameter int CLK_HZ         = 1000,
    parameter int SEC_PER_UNIT   = 2,
    parameter int MAX_AMOUNT     = 20,
    parameter int IDLE_TIMEOUT_S = 10
) (
    input  logic           clk,
    input  logic           rst,
    charge_session_if.slave bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_INPUT  = 2'd1,
        S_CHARGE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      amount_q, amount_d;
    logic [1:0]      digit_q, digit_d;
    logic [7:0]      remaining_q, remaining_d;
    logic            done_q, done_d;
    logic            power_on_q, charging_q;
    logic [PW-1:0]   presc_q, presc_d, presc_step_s;
    logic [IW-1:0]   idle_q, idle_d;
    logic            tick_s, any_key_s;
    logic [10:0]     entry_s;
    logic [15:0]     charge_secs_s;

    assign tick_s        = (presc_q == PW'(CLK_HZ - 1));
    assign presc_step_s  = tick_s ? '0 : presc_q + PW'(1);
    assign any_key_s     = bus.start | bus.clear | bus.confirm | bus.press_num;
    assign entry_s       = (11'(amount_q) * 11'd10) + 11'(bus.key_value);
    assign charge_secs_s = 16'(amount_q) * 16'(SEC_PER_UNIT);

    // Next-state logic: key priority start > clear > confirm > press_num, plus tick-driven timing.
    always_comb begin
        state_d     = state_q;
        amount_d    = amount_q;
        digit_d     = digit_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        presc_d     = presc_q;
        idle_d      = idle_q;
        case (state_q)
            S_OFF: begin
                presc_d = '0;
                idle_d  = '0;
                if (bus.start) begin
                    state_d  = S_INPUT;
                    amount_d = 7'd0;
                    digit_d  = 2'd0;
                end else begin
                    state_d = S_OFF;
                end
            end
            S_INPUT: begin
                presc_d = presc_step_s;
                idle_d  = tick_s ? idle_q + IW'(1) : idle_q;
                if (any_key_s) begin
                    presc_d = '0;
                    idle_d  = '0;
                end else begin
                    presc_d = presc_d;
                end
                if (bus.start || bus.clear) begin
                    amount_d = 7'd0;
                    digit_d  = 2'd0;
                end else if (bus.confirm) begin
                    if (amount_q != 7'd0) begin
                        state_d     = S_CHARGE;
                        remaining_d = charge_secs_s[7:0];
                    end else begin
                        state_d = S_INPUT;
                    end
                end else if (bus.press_num) begin
                    if ((bus.key_value <= 4'd9) && (digit_q < 2'd2)) begin
                        amount_d = (entry_s > 11'(MAX_AMOUNT)) ? 7'(MAX_AMOUNT) : entry_s[6:0];
                        digit_d  = digit_q + 2'd1;
                    end else begin
                        digit_d = digit_q;
                    end
                end else if (tick_s && (idle_q == IW'(IDLE_TIMEOUT_S - 1))) begin
                    state_d  = S_OFF;
                    amount_d = 7'd0;
                    digit_d  = 2'd0;
                    idle_d   = '0;
                end else begin
                    state_d = S_INPUT;
                end
            end
            S_CHARGE: begin
                presc_d = presc_step_s;
                idle_d  = '0;
`ifdef CHARGE_ABORT_EN
                if (bus.clear) begin
                    state_d     = S_INPUT;
                    remaining_d = 8'd0;
                    amount_d    = 7'd0;
                    digit_d     = 2'd0;
                    presc_d     = '0;
                end else
`endif
                if (tick_s) begin
                    remaining_d = remaining_q - 8'd1;
                    // Countdown end hands back to entry with a fresh prescaler (wrapped on tick).
                    if (remaining_q <= 8'd1) begin
                        state_d     = S_INPUT;
                        remaining_d = 8'd0;
                        amount_d    = 7'd0;
                        digit_d     = 2'd0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = S_CHARGE;
                    end
                end else begin
                    state_d = S_CHARGE;
                end
            end
            default: begin
                state_d     = S_OFF;
                amount_d    = 7'd0;
                digit_d     = 2'd0;
                remaining_d = 8'd0;
                presc_d     = '0;
                idle_d      = '0;
            end
        endcase
    end

    // Session state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OFF;
            amount_q    <= 7'd0;
            digit_q     <= 2'd0;
            remaining_q <= 8'd0;
            done_q      <= 1'b0;
            power_on_q  <= 1'b0;
            charging_q  <= 1'b0;
            presc_q     <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            amount_q    <= amount_d;
            digit_q     <= digit_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            power_on_q  <= (state_d != S_OFF);
            charging_q  <= (state_d == S_CHARGE);
            presc_q     <= presc_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.power_on  = power_on_q;
    assign bus.charging  = charging_q;
    assign bus.amount    = amount_q;
    assign bus.digit_cnt = digit_q;
    assign bus.remaining = remaining_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed scoreboard bench for charge_session_ctrl (CLK_HZ=1000, SEC_PER_UNIT=2, MAX_AMOUNT=20, IDLE_TIMEOUT_S=10).
module tb_charge_session_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    charge_session_if bus ();

    charge_session_ctrl #(
        .CLK_HZ(1000), .SEC_PER_UNIT(2), .MAX_AMOUNT(20), .IDLE_TIMEOUT_S(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
            end
        end
    endtask

    task automatic expect_sad(input string tag, input int st, input int amt, input int dig);
        push({tag, "_state"}, 32'(st));
        push({tag, "_power_on"}, (st != 0) ? 32'd1 : 32'd0);
        push({tag, "_amount"}, 32'(amt));
        push({tag, "_digit_cnt"}, 32'(dig));
    endtask

    task automatic check_sad();
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.power_on));
        pop_chk(32'(bus.amount));
        pop_chk(32'(bus.digit_cnt));
    endtask

    task automatic expect_crd(input string tag, input int chg, input int rem, input int dn);
        push({tag, "_charging"}, 32'(chg));
        push({tag, "_remaining"}, 32'(rem));
        push({tag, "_done"}, 32'(dn));
    endtask

    task automatic check_crd();
        pop_chk(32'(bus.charging));
        pop_chk(32'(bus.remaining));
        pop_chk(32'(bus.done));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic c, input logic cf, input logic pn, input logic [3:0] kv);
        bus.start     = s;
        bus.clear     = c;
        bus.confirm   = cf;
        bus.press_num = pn;
        bus.key_value = kv;
        step();
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.confirm   = 1'b0;
        bus.press_num = 1'b0;
        bus.key_value = 4'd0;
    endtask

    task automatic digit(input logic [3:0] kv);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, kv);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.clear = 1'b0; bus.confirm = 1'b0;
        bus.press_num = 1'b0; bus.key_value = 4'd0;
        repeat (3) step();
        expect_sad("reset", 0, 0, 0); expect_crd("reset", 0, 0, 0);
        check_sad(); check_crd();
        rst = 1'b0;
        step();
        expect_sad("off_confirm", 0, 0, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); check_sad();

        // Normal charge: 12 units -> 24 s -> 24000 cycles
        expect_sad("start", 1, 0, 0); pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); check_sad();
        expect_sad("dig1", 1, 1, 1);  digit(4'd1); check_sad();
        expect_sad("dig2", 1, 12, 2); digit(4'd2); check_sad();
        expect_sad("confirm", 2, 12, 2); expect_crd("confirm", 1, 24, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); check_sad(); check_crd();
        repeat (999) step();
        expect_crd("pre_tick", 1, 24, 0); check_crd();
        step();
        expect_crd("first_tick", 1, 23, 0); check_crd();
        repeat (22999) step();
        expect_crd("last_cycle", 1, 1, 0); check_crd();
        expect_sad("done", 1, 0, 0); expect_crd("done", 0, 0, 1);
        step(); check_sad(); check_crd();
        expect_crd("done_once", 0, 0, 0); step(); check_crd();

        // Clamp, digit limit, invalid key, leading zero
        expect_sad("dig3", 1, 3, 1);    digit(4'd3);  check_sad();
        expect_sad("clamp", 1, 20, 2);  digit(4'd5);  check_sad();
        expect_sad("third", 1, 20, 2);  digit(4'd7);  check_sad();
        expect_sad("key11", 1, 20, 2);  digit(4'd11); check_sad();
        expect_sad("clr", 1, 0, 0);     pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); check_sad();
        expect_sad("key11b", 1, 0, 0);  digit(4'd11); check_sad();
        expect_sad("lead0", 1, 0, 1);   digit(4'd0);  check_sad();
        expect_sad("d07", 1, 7, 2);     digit(4'd7);  check_sad();

        // Clear then zero confirm
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        digit(4'd1);
        expect_sad("d12", 1, 12, 2); digit(4'd2); check_sad();
        expect_sad("clr12", 1, 0, 0); pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); check_sad();
        expect_sad("zero_conf", 1, 0, 0); expect_crd("zero_conf", 0, 0, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); check_sad(); check_crd();

        // Idle timeout, with and without a late key
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (9999) step();
        expect_sad("idle_9999", 1, 0, 0); check_sad();
        expect_sad("idle_off", 0, 0, 0); step(); check_sad();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (9998) step();
        expect_sad("late_key", 1, 0, 0); pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd12); check_sad();
        repeat (9999) step();
        expect_sad("late_9999", 1, 0, 0); check_sad();
        expect_sad("late_off", 0, 0, 0); step(); check_sad();

        // Async reset mid-charge
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        digit(4'd8);
        expect_crd("conf8", 1, 16, 0); pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); check_crd();
        repeat (1000) step();
        expect_crd("rem15", 1, 15, 0); check_crd();
        rst = 1'b1;
        #1;
        expect_sad("async_rst", 0, 0, 0); expect_crd("async_rst", 0, 0, 0);
        check_sad(); check_crd();
        repeat (3) step();
        rst = 1'b0;
        step();
        expect_sad("post_rst", 0, 0, 0); check_sad();
        expect_sad("post_rst_conf", 0, 0, 0); pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0); check_sad();
        expect_sad("post_rst_dig", 0, 0, 0);  digit(4'd5); check_sad();
        expect_sad("fresh", 1, 0, 0); expect_crd("fresh", 0, 0, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0); check_sad(); check_crd();

        // Priority and abort behaviour
        expect_sad("p5", 1, 5, 1); digit(4'd5); check_sad();
        expect_sad("start_clr", 1, 0, 0); pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'd0); check_sad();
        digit(4'd5);
        expect_sad("clr_conf", 1, 0, 0); pulse(1'b0, 1'b1, 1'b1, 1'b1, 4'd3); check_sad();
        digit(4'd5);
        expect_sad("conf_num", 2, 5, 1); expect_crd("conf_num", 1, 10, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 4'd3); check_sad(); check_crd();
        repeat (500) step();
`ifdef CHARGE_ABORT_EN
        expect_sad("abort", 1, 0, 0); expect_crd("abort", 0, 0, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); check_sad(); check_crd();
        expect_sad("abort_after", 1, 0, 0); expect_crd("abort_after", 0, 0, 0);
        step(); check_sad(); check_crd();
`else
        expect_sad("no_abort", 2, 5, 1); expect_crd("no_abort", 1, 10, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); check_sad(); check_crd();
        repeat (498) step();
        expect_crd("no_abort_pre", 1, 10, 0); check_crd();
        expect_crd("no_abort_tick", 1, 9, 0); step(); check_crd();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/charge_session_ctrl.md
# charge_session_ctrl

Session controller for the coin-operated charger. Consumes the one-cycle key-event pulses from the keyboard scanner (`key_value`, `press_num`, `start`, `clear`, `confirm`) and sequences a charge session:
- power-on;
- amount entry, up to 2 decimal digits;
- timed charging countdown;
- idle timeout.

It sits between the scanner and the display/relay logic and owns all session state.

## Interface
Parameters:
- `CLK_HZ`, 1000: clock cycles per second; the one-second tick period.
- `SEC_PER_UNIT`, 2: charge seconds per unit of amount.
- `MAX_AMOUNT`, 20: amount clamp, 1..99. Constraint: `MAX_AMOUNT*SEC_PER_UNIT` ≤ 255.
- `IDLE_TIMEOUT_S`, 10: seconds without any key event in INPUT before returning to OFF.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `key_value` in 4: key code, valid when `press_num`=1; digits are 0..9.
- `press_num` in 1: one-cycle pulse, numeric key pressed.
- `start` in 1: one-cycle pulse, start key.
- `clear` in 1: one-cycle pulse, clear key.
- `confirm` in 1: one-cycle pulse, confirm key.
- `state` out 2: session state; OFF=0, INPUT=1, CHARGE=2.
- `power_on` out 1: high when state ≠ OFF.
- `charging` out 1: high in CHARGE (relay enable).
- `amount` out 7: entered amount, binary.
- `digit_cnt` out 2: digits accepted so far, 0..2.
- `remaining` out 8: charge seconds left.
- `done` out 1: one-cycle pulse when a charge completes normally.

## Operation
- All outputs are registered. While `rst`=1, every output is 0 and the state is OFF.
- Key-event priority when pulses coincide: `start` > `clear` > `confirm` > `press_num`. Only the winner acts.
- **OFF**
  - `start` → INPUT; `amount`=0, `digit_cnt`=0.
  - All other keys are ignored.
- **INPUT**
  - `start` restarts entry: `amount`=0, `digit_cnt`=0.
  - `clear` sets `amount`=0 and `digit_cnt`=0.
  - `press_num` with `key_value` ≤ 9 and `digit_cnt` < 2:
    - new amount = `amount*10 + key_value`, clamped to `MAX_AMOUNT`;
    - `digit_cnt` increments;
    - a leading 0 counts as a digit.
  - `press_num` with `key_value` > 9, or with `digit_cnt`=2: ignored.
  - `confirm` with `amount`=0: ignored.
  - `confirm` with `amount` > 0: → CHARGE, `remaining` = `amount*SEC_PER_UNIT`.
  - Idle timeout: after `IDLE_TIMEOUT_S` consecutive seconds with no key pulse of any kind → OFF, `amount`=0, `digit_cnt`=0.
- **CHARGE**
  - `remaining` decrements by 1 on each second tick.
  - On the tick where `remaining` goes 1→0: → INPUT, `done`=1 for that cycle, `amount`=0, `digit_cnt`=0.
  - All keys are ignored (see Configuration for `clear`).
- **Second tick**
  - Prescaler counts 0..`CLK_HZ`-1; the tick fires when it reaches `CLK_HZ`-1.
  - The prescaler and the idle-second counter clear on entry to INPUT or CHARGE.
  - In INPUT they also clear on any key pulse, whether accepted or ignored.
  - The idle counter only runs in INPUT.

## Timing
- Response latency: a key pulse sampled at edge k updates outputs after edge k.
- `confirm` accepted at edge k:
  - CHARGE from edge k;
  - first decrement `CLK_HZ` cycles later;
  - `charging` stays high for exactly `amount*SEC_PER_UNIT*CLK_HZ` cycles;
  - `done` rises in the same cycle `charging` falls.
- Idle timeout: with the last key event or INPUT entry at edge k, OFF is reached at edge k + `IDLE_TIMEOUT_S*CLK_HZ`.
- `rst` mid-session: outputs go to 0 immediately, with no clock needed. The first `start` after release begins a fresh session.

## Configuration
- Macro `CHARGE_ABORT_EN`.
- Defined: `clear` in CHARGE aborts the charge on the next edge:
  - → INPUT, `remaining`=0, `amount`=0, `digit_cnt`=0;
  - `done` is not pulsed.
- Undefined: `clear` in CHARGE is ignored, like every other key.

## Test plan
- Normal charge: reset, then `start`, digits 1, 2, `confirm`.
  - Expect `amount`=12, `remaining`=24, `charging`=1.
  - After 24000 cycles: `done` pulses once, state=1, `amount`=0.
- Clamp and digit limit: INPUT, digits 3, 5 → `amount`=20, `digit_cnt`=2.
  - Then digit 7 → no change.
  - Then `press_num` with `key_value`=11 → no change.
- Clear and zero confirm: digits 1, 2, then `clear` → `amount`=0, `digit_cnt`=0.
  - Then `confirm` → state stays 1, `charging`=0.
- Idle timeout: `start`, then no keys → state=0 exactly 10000 cycles after `start`.
  - A key pulse at cycle 9999 pushes OFF to 10000 cycles after that pulse.
- Async reset: assert `rst` with `remaining`=15 in CHARGE.
  - Expect all outputs 0 before the next clock edge.
  - After release, state=0 until `start`.
- Priority and abort: `start` and `clear` in the same cycle during INPUT with `amount`=5 → `amount`=0, `digit_cnt`=0.
  - `clear` mid-charge with `CHARGE_ABORT_EN` → state=1, `done`=0.
  - `clear` mid-charge without it → countdown continues unchanged.
